// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider, h/v sweep with run/halt on frame
// boundaries, and registered colour, syncs and line/frame markers.
module vga_timing_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 29,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter bit V_SYNC_POL  = 1'b0,
    parameter int CLK_DIV     = 2,
    parameter int COLOR_WIDTH = 3,
    parameter int CNT_WIDTH   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [COLOR_WIDTH-1:0] pixelIn,
    output logic [CNT_WIDTH-1:0]   pixelX,
    output logic [CNT_WIDTH-1:0]   pixelY,
    output logic                   pixelReq,
    output logic [COLOR_WIDTH-1:0] color,
    output logic                   hSync,
    output logic                   vSync,
    output logic                   frameStart,
    output logic                   lineStart
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]     DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] H_VIS   = CNT_WIDTH'(H_DISPLAY);
    localparam logic [CNT_WIDTH-1:0] V_VIS   = CNT_WIDTH'(V_DISPLAY);
    localparam logic [CNT_WIDTH-1:0] H_SS    = CNT_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_WIDTH-1:0] H_SE    = CNT_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_WIDTH-1:0] V_SS    = CNT_WIDTH'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_WIDTH-1:0] V_SE    = CNT_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [CNT_WIDTH-1:0]   hc_q, hc_d, vc_q, vc_d;
    logic [COLOR_WIDTH-1:0] color_q, color_d;
    logic                   hs_q, hs_d, vs_q, vs_d;
    logic                   fs_q, fs_d, ls_q, ls_d;
    logic                   tick, active, h_win, v_win;

    assign tick     = (div_q == DIV_MAX);
    assign active   = (state_q == ACTIVE);
    assign pixelReq = active && (hc_q < H_VIS) && (vc_q < V_VIS);
    assign h_win    = active && (hc_q >= H_SS) && (hc_q < H_SE);
    assign v_win    = active && (vc_q >= V_SS) && (vc_q < V_SE);

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        state_d = state_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    hc_d = '0;
                    vc_d = '0;
                    if (run) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (hc_q == H_LAST) begin
                        hc_d = '0;
                        // run only matters on the last pixel of a frame
                        if (vc_q == V_LAST) begin
                            vc_d = '0;
                            if (!run) state_d = IDLE;
                        end else begin
                            vc_d = vc_q + 1'b1;
                        end
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        color_d = color_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        if (tick) begin
            color_d = pixelReq ? pixelIn : '0;
            hs_d    = h_win ? H_SYNC_POL : ~H_SYNC_POL;
            vs_d    = v_win ? V_SYNC_POL : ~V_SYNC_POL;
        end
        ls_d = tick && active && (hc_q == '0);
        fs_d = ls_d && (vc_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            hc_q    <= '0;
            vc_q    <= '0;
            color_q <= '0;
            hs_q    <= ~H_SYNC_POL;
            vs_q    <= ~V_SYNC_POL;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            color_q <= color_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
        end
    end

    assign pixelX     = hc_q;
    assign pixelY     = vc_q;
    assign color      = color_q;
    assign hSync      = hs_q;
    assign vSync      = vs_q;
    assign frameStart = fs_q;
    assign lineStart  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default mode (A), small CLK_DIV=1 mode with positive
// syncs (B), and small CLK_DIV=3 mode for mid-frame halt and restart (C).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // A: default mode
    logic       rstA = 1'b0, runA = 1'b1;
    logic [9:0] pxA, pyA;
    logic [2:0] colA;
    logic       reqA, hsA, vsA, fsA, lsA;

    vga_timing_gen dutA (
        .clk(clk), .rst(rstA), .run(runA), .pixelIn(pxA[2:0]),
        .pixelX(pxA), .pixelY(pyA), .pixelReq(reqA), .color(colA),
        .hSync(hsA), .vSync(vsA), .frameStart(fsA), .lineStart(lsA)
    );

    // B: 8/2/2/2 x 4/1/1/1, CLK_DIV=1, active-high syncs
    logic       rstB = 1'b0, runB = 1'b1;
    logic [9:0] pxB, pyB;
    logic [2:0] colB;
    logic       reqB, hsB, vsB, fsB, lsB;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1),
        .COLOR_WIDTH(3), .CNT_WIDTH(10)
    ) dutB (
        .clk(clk), .rst(rstB), .run(runB), .pixelIn(pxB[2:0]),
        .pixelX(pxB), .pixelY(pyB), .pixelReq(reqB), .color(colB),
        .hSync(hsB), .vSync(vsB), .frameStart(fsB), .lineStart(lsB)
    );

    // C: same small mode, CLK_DIV=3, active-low syncs
    logic       rstC = 1'b0, runC = 1'b1;
    logic [9:0] pxC, pyC;
    logic [2:0] colC;
    logic       reqC, hsC, vsC, fsC, lsC;
    int         ecC;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(3), .COLOR_WIDTH(3), .CNT_WIDTH(10)
    ) dutC (
        .clk(clk), .rst(rstC), .run(runC), .pixelIn(pxC[2:0]),
        .pixelX(pxC), .pixelY(pyC), .pixelReq(reqC), .color(colC),
        .hSync(hsC), .vSync(vsC), .frameStart(fsC), .lineStart(lsC)
    );

    // edges since C left reset; ticks fall on multiples of 3
    always @(posedge clk or negedge rstC)
        if (!rstC) ecC <= 0;
        else ecC <= ecC + 1;

    initial begin
        int cnt;
        int nfs;

        // ---------------- A ----------------
        repeat (3) @(negedge clk);
        check("a_rst_hs", hsA, 1);
        check("a_rst_vs", vsA, 1);
        check("a_rst_col", colA, 0);
        check("a_rst_px", pxA, 0);
        check("a_rst_req", reqA, 0);
        check("a_rst_fs", fsA, 0);
        rstA = 1'b1;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (fsA) break;
        end
        check("a_first_fs_lat", cnt, 4);

        for (int i = 0; i <= 3000; i++) begin
            case (i)
                0:    begin check("a_ls0", lsA, 1); check("a_px0", pxA, 1); end
                1:    begin check("a_ls1", lsA, 0); check("a_fs1", fsA, 0); end
                10:   check("a_col5", colA, 5);
                11:   check("a_col5_hold", colA, 5);
                1276: check("a_req639", reqA, 1);
                1278: begin check("a_col639", colA, 7); check("a_req640", reqA, 0); end
                1280: check("a_col640", colA, 0);
                1311: check("a_hs655", hsA, 1);
                1312: check("a_hs656", hsA, 0);
                1502: check("a_hs751", hsA, 0);
                1504: check("a_hs752", hsA, 1);
                1000: check("a_vs_line0", vsA, 1);
                1600: begin
                    check("a_ls_line1", lsA, 1);
                    check("a_fs_line1", fsA, 0);
                    check("a_py_line1", pyA, 1);
                end
                1601: check("a_ls_line1_end", lsA, 0);
                1606: check("a_col_l1h3", colA, 3);
                3000: check("a_hs_l1h700", hsA, 0);
                default: ;
            endcase
            if (i < 3000) @(negedge clk);
        end
        #2 rstA = 1'b0;
        #1;
        check("a_mid_rst_hs", hsA, 1);
        check("a_mid_rst_vs", vsA, 1);
        check("a_mid_rst_col", colA, 0);
        check("a_mid_rst_px", pxA, 0);
        check("a_mid_rst_py", pyA, 0);
        check("a_mid_rst_ls", lsA, 0);
        @(negedge clk);
        rstA = 1'b1;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (fsA) break;
        end
        check("a_refs_lat", cnt, 4);
        check("a_refs_py", pyA, 0);

        // ---------------- B ----------------
        @(negedge clk);
        rstB = 1'b1;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (fsB) break;
        end
        check("b_first_fs_lat", cnt, 2);
        for (int j = 0; j <= 196; j++) begin
            case (j)
                2:   check("b_req_h3", reqB, 1);
                3:   check("b_col3", colB, 3);
                7:   begin check("b_col7", colB, 7); check("b_req_h8", reqB, 0); end
                8:   check("b_col8", colB, 0);
                9:   check("b_hs9", hsB, 0);
                10:  check("b_hs10", hsB, 1);
                11:  check("b_hs11", hsB, 1);
                12:  check("b_hs12", hsB, 0);
                13:  check("b_ls13", lsB, 0);
                14:  begin check("b_ls14", lsB, 1); check("b_fs14", fsB, 0); end
                41:  check("b_req_l3", reqB, 1);
                55:  check("b_req_l4", reqB, 0);
                59:  check("b_col_l4", colB, 0);
                69:  check("b_vs_l4", vsB, 0);
                70:  check("b_vs_l5a", vsB, 1);
                83:  check("b_vs_l5b", vsB, 1);
                84:  check("b_vs_l6", vsB, 0);
                98:  check("b_fs98", fsB, 1);
                194: runB = 1'b0;
                195: begin check("b_end_hs", hsB, 0); check("b_end_vs", vsB, 0); end
                196: begin
                    check("b_no_extra_fs", fsB, 0);
                    check("b_idle_ls", lsB, 0);
                    check("b_idle_px", pxB, 0);
                    check("b_idle_py", pyB, 0);
                    check("b_idle_req", reqB, 0);
                    check("b_idle_col", colB, 0);
                end
                default: ;
            endcase
            if (j < 196) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("b_idle_px_late", pxB, 0);
        runB = 1'b1;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (fsB) break;
        end
        check("b_restart_lat", cnt, 2);

        // ---------------- C ----------------
        @(negedge clk);
        rstC = 1'b1;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (fsC) break;
        end
        check("c_first_fs_lat", cnt, 6);
        cnt = 0;
        while (cnt < 400 && pyC != 10'd2) begin
            @(negedge clk);
            cnt++;
        end
        check("c_reach_v2", pyC, 2);
        runC = 1'b0;
        cnt = 0;
        while (cnt < 400 && !(pxC == 10'd13 && pyC == 10'd6)) begin
            @(negedge clk);
            cnt++;
        end
        check("c_frame_completes_x", pxC, 13);
        check("c_frame_completes_y", pyC, 6);
        repeat (6) @(negedge clk);
        check("c_idle_px", pxC, 0);
        check("c_idle_py", pyC, 0);
        check("c_idle_hs", hsC, 1);
        check("c_idle_vs", vsC, 1);
        check("c_idle_col", colC, 0);
        check("c_idle_req", reqC, 0);
        nfs = 0;
        repeat (400) begin
            @(negedge clk);
            if (fsC || lsC) nfs++;
        end
        check("c_idle_no_pulses", nfs, 0);
        cnt = 0;
        while (cnt < 10 && (ecC % 3) != 0) begin
            @(negedge clk);
            cnt++;
        end
        check("c_phase_found", ecC % 3, 0);
        runC = 1'b1;
        cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (fsC) break;
        end
        check("c_restart_lat", cnt, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
